// File: rtl/relprime_checker.sv
// rtl/relprime_checker.sv - checks that m is the smallest integer >= 2 coprime to n
// Optional cycle counter output enabled by RELPRIME_CHECK_CYCLES_EN.
module relprime_checker #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [WIDTH-1:0] fail_k,
    output logic [WIDTH-1:0] gcd_out
`ifdef RELPRIME_CHECK_CYCLES_EN
    ,
    output logic [31:0]      cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GCD,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [1:0] CODE_OK          = 2'd0;
    localparam logic [1:0] CODE_NOT_COPRIME = 2'd1;
    localparam logic [1:0] CODE_NOT_MINIMAL = 2'd2;
    localparam logic [1:0] CODE_BAD_INPUT   = 2'd3;

    state_t           state, state_nx;
    logic [WIDTH-1:0] n_r, n_nx;
    logic [WIDTH-1:0] m_r, m_nx;
    logic [WIDTH-1:0] k_r, k_nx;
    logic [WIDTH-1:0] a_r, a_nx;
    logic [WIDTH-1:0] b_r, b_nx;
    logic             pass_nx;
    logic [1:0]       code_nx;
    logic [WIDTH-1:0] fail_k_nx;
    logic [WIDTH-1:0] gcd_nx;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            n_r       <= '0;
            m_r       <= '0;
            k_r       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            pass      <= 1'b0;
            fail_code <= CODE_OK;
            fail_k    <= '0;
            gcd_out   <= '0;
        end else begin
            state     <= state_nx;
            n_r       <= n_nx;
            m_r       <= m_nx;
            k_r       <= k_nx;
            a_r       <= a_nx;
            b_r       <= b_nx;
            pass      <= pass_nx;
            fail_code <= code_nx;
            fail_k    <= fail_k_nx;
            gcd_out   <= gcd_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n_r;
        m_nx      = m_r;
        k_nx      = k_r;
        a_nx      = a_r;
        b_nx      = b_r;
        pass_nx   = pass;
        code_nx   = fail_code;
        fail_k_nx = fail_k;
        gcd_nx    = gcd_out;
        case (state)
            S_IDLE: begin
                if (start) begin
                    n_nx      = n;
                    m_nx      = m;
                    k_nx      = WIDTH'(2);
                    pass_nx   = 1'b0;
                    code_nx   = CODE_OK;
                    fail_k_nx = '0;
                    gcd_nx    = '0;
                    state_nx  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (n_r == '0 || m_r < WIDTH'(2)) begin
                    code_nx   = CODE_BAD_INPUT;
                    fail_k_nx = m_r;
                    gcd_nx    = '0;
                    state_nx  = S_DONE;
                end else begin
                    a_nx     = n_r;
                    b_nx     = k_r;
                    state_nx = S_GCD;
                end
            end
            S_GCD: begin
                // Subtractive Euclid; a holds the gcd once b reaches zero.
                if (b_r == '0) begin
                    state_nx = S_EVAL;
                end else if (a_r >= b_r) begin
                    a_nx = a_r - b_r;
                end else begin
                    a_nx = b_r;
                    b_nx = a_r;
                end
            end
            S_EVAL: begin
                fail_k_nx = k_r;
                gcd_nx    = a_r;
                state_nx  = S_DONE;
                if (k_r < m_r) begin
                    if (a_r == WIDTH'(1)) begin
                        code_nx = CODE_NOT_MINIMAL;
                    end else begin
                        fail_k_nx = fail_k;
                        gcd_nx    = gcd_out;
                        k_nx      = k_r + WIDTH'(1);
                        state_nx  = S_LOAD;
                    end
                end else if (a_r == WIDTH'(1)) begin
                    pass_nx = 1'b1;
                    code_nx = CODE_OK;
                end else begin
                    code_nx = CODE_NOT_COPRIME;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_LOAD) || (state == S_GCD) || (state == S_EVAL);
    assign done = (state == S_DONE);

`ifdef RELPRIME_CHECK_CYCLES_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if (state == S_IDLE && start) begin
            cycles <= '0;
        end else if (busy && cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_relprime_checker.sv
// tb/tb_relprime_checker.sv - directed self-checking bench for relprime_checker
module tb_relprime_checker;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n = '0;
    logic [15:0] m = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [15:0] fail_k;
    logic [15:0] gcd_out;
`ifdef RELPRIME_CHECK_CYCLES_EN
    logic [31:0] cycles;
`endif

    relprime_checker #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .n         (n),
        .m         (m),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code),
        .fail_k    (fail_k),
        .gcd_out   (gcd_out)
`ifdef RELPRIME_CHECK_CYCLES_EN
        ,
        .cycles    (cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_count = 0;
    int unsigned exp_n = 0;
    int unsigned exp_m = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int unsigned gcd_f(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Expected verdict straight from the definition of "smallest coprime >= 2".
    task automatic model(input int unsigned nn, input int unsigned mm, output logic p,
                         output logic [1:0] c, output int unsigned fk, output int unsigned g);
        p = 1'b0; c = 2'd3; fk = mm; g = 0;
        if (nn == 0 || mm < 2) return;
        for (int unsigned k = 2; k <= mm; k++) begin
            g = gcd_f(nn, k);
            fk = k;
            if (g == 1) begin
                if (k < mm) c = 2'd2;
                else begin p = 1'b1; c = 2'd0; end
                return;
            end
            if (k == mm) begin c = 2'd1; return; end
        end
    endtask

    logic        cp_pass;
    logic [1:0]  cp_code;
    int unsigned cp_k, cp_g;

    always @(negedge CLK) begin
        if (!reset && done) begin
            model(exp_n, exp_m, cp_pass, cp_code, cp_k, cp_g);
            chk("done_pass", pass, cp_pass);
            chk("done_fail_code", fail_code, cp_code);
            chk("done_fail_k", fail_k, cp_k);
            chk("done_gcd_out", gcd_out, cp_g);
            chk("done_busy_low", busy, 0);
            done_count++;
        end
    end

    task automatic run(input int unsigned nn, input int unsigned mm, input int hold,
                       output int lat);
        int dc0;
        dc0 = done_count;
        @(negedge CLK);
        #1;
        n = nn[15:0]; m = mm[15:0]; exp_n = nn; exp_m = mm;
        start = 1'b1;
        lat = 0;
        while (done_count == dc0 && lat < 60000) begin
            @(negedge CLK);
            #1;
            lat++;
            if (lat == hold) start = 1'b0;
        end
        start = 1'b0;
        if (done_count == dc0) chk("done_timeout", lat, -1);
    endtask

    task automatic pin_model(input int unsigned nn, input int unsigned mm, input logic p,
                             input logic [1:0] c, input int unsigned fk, input int unsigned g);
        logic        mp;
        logic [1:0]  mc;
        int unsigned mk, mg;
        model(nn, mm, mp, mc, mk, mg);
        chk("model_pass", mp, p);
        chk("model_code", mc, c);
        chk("model_k", mk, fk);
        chk("model_gcd", mg, g);
    endtask

    initial begin
        int lat;
        int dc;

        pin_model(34596, 5, 1'b1, 2'd0, 5, 1);
        pin_model(34596, 7, 1'b0, 2'd2, 5, 1);
        pin_model(34596, 4, 1'b0, 2'd1, 4, 4);
        pin_model(0, 5, 1'b0, 2'd3, 5, 0);
        pin_model(9, 1, 1'b0, 2'd3, 1, 0);
        pin_model(30, 7, 1'b1, 2'd0, 7, 1);
        pin_model(1116, 7, 1'b0, 2'd2, 5, 1);

        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_fail_k", fail_k, 0);
        chk("rst_gcd_out", gcd_out, 0);
        @(negedge CLK);
        reset = 1'b0;

        run(34596, 5, 2, lat);
        dc = done_count;
`ifdef RELPRIME_CHECK_CYCLES_EN
        chk("cycles_nonzero", (cycles != 0), 1);
        begin
            logic [31:0] c0;
            c0 = cycles;
            repeat (5) @(negedge CLK);
            chk("cycles_hold", cycles, c0);
        end
`endif
        repeat (20) @(negedge CLK);
        chk("no_second_run", done_count, dc);

        run(1116, 7, 1, lat);
        run(1116, 4, 1, lat);
        run(0, 5, 1, lat);
        chk("bad_latency_n0", (lat <= 3), 1);
        run(9, 1, 1, lat);
        chk("bad_latency_m1", (lat <= 3), 1);
        run(1, 2, 1, lat);
        run(30, 7, 1, lat);

        @(negedge CLK);
        n = 16'd34596; m = 16'd5; exp_n = 34596; exp_m = 5;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        chk("pre_reset_busy", busy, 1);
        dc = done_count;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_fail_code", fail_code, 0);
        chk("mid_rst_fail_k", fail_k, 0);
        chk("mid_rst_gcd_out", gcd_out, 0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (100) @(negedge CLK);
        chk("no_done_after_abort", done_count, dc);
        chk("idle_after_abort", busy, 0);

        run(1116, 5, 1, lat);
        chk("fresh_run_done", done_count, dc + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/relprime_checker.md
Name: relprime_checker

Overview:
Verification-side companion to the relprime core. It takes a value n and a claimed result m, and independently checks that m is the smallest integer ≥2 coprime to n. It sits beside the relprime core in self-checking top levels. It consumes the core's `out` as m and drives a pass/fail verdict, so the existing bench no longer has to compare against hand-computed values.

Parameters:
- WIDTH, 16, datapath width of n, m, candidate k and the GCD registers.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- n  in  WIDTH  value under test (the core's register_value).
- m  in  WIDTH  claimed relprime result (the core's out).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the verdict is valid.
- pass  out  1  1 = m verified minimal coprime.
- fail_code  out  2  0 OK, 1 NOT_COPRIME, 2 NOT_MINIMAL, 3 BAD_INPUT.
- fail_k  out  WIDTH  candidate k at which the verdict was decided.
- gcd_out  out  WIDTH  gcd(n, fail_k) computed at the decision point.

Behaviour:
- Reset (async, immediate), with every output 0:
  - busy=0, done=0, pass=0, fail_code=0, fail_k=0, gcd_out=0.
  - FSM returns to IDLE.
  - Reset mid-check aborts the check; no done pulse is produced.
- States: IDLE, LOAD, GCD, EVAL, DONE.
- IDLE:
  - On start=1, latch n→N_r and m→M_r, set k=2, go to LOAD.
  - Verdict outputs hold their previous values until start is accepted.
  - Accepting start clears pass, fail_code, fail_k and gcd_out.
- Start while busy is ignored. Inputs are not re-sampled after latching.
- Input validation (checked in LOAD before any GCD work): if N_r==0 or M_r<2, go to DONE with fail_code=3, fail_k=M_r, gcd_out=0.
- LOAD: a←N_r, b←k; go to GCD.
- GCD performs one step per cycle, subtractive Euclid:
  - if b==0 → go to EVAL (gcd = a);
  - else if a≥b → a←a−b;
  - else swap a and b.
- EVAL:
  - k<M_r and gcd==1 → DONE with fail_code=2.
  - k<M_r and gcd≠1 → k←k+1, go to LOAD.
  - k==M_r and gcd==1 → DONE with pass=1, fail_code=0.
  - k==M_r and gcd≠1 → DONE with fail_code=1.
  - In every DONE case, fail_k=k and gcd_out=gcd.
- Candidates are checked in ascending order, so a smaller coprime is always reported before NOT_COPRIME.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then go to IDLE.
  - A start asserted during the DONE cycle is ignored.
  - A start held high into IDLE is accepted on the next edge.
- Width: all arithmetic is unsigned WIDTH bits. The subtraction never underflows because it is guarded by a≥b. k cannot wrap, since k≤M_r≤2^WIDTH−1.
- Latency: 1 (LOAD) + GCD steps + 1 (EVAL) per candidate, plus 1 DONE cycle. It is bounded but data-dependent; the bench must wait on done, not on a fixed count.

Optional Feature:
- Macro: RELPRIME_CHECK_CYCLES_EN.
- When defined:
  - Adds output `cycles` [31:0], which counts CLK edges with busy=1 during the current check.
  - The counter clears on start acceptance and holds after done.
  - It saturates at 0xFFFFFFFF.
  - Reset value is 0.
- When undefined: the port and counter are absent, and the remaining logic is identical.

Test Plan:
- n=34596, m=5, start pulse for 2 cycles → one done pulse; pass=1, fail_code=0, fail_k=5, gcd_out=1. The start held during busy is ignored and does not cause a second run.
- n=34596, m=7 → pass=0, fail_code=2, fail_k=5, gcd_out=1.
- n=34596, m=4 → fail_code=1, fail_k=4, gcd_out=4.
- n=0, m=5 → fail_code=3, fail_k=5, gcd_out=0. Also n=9, m=1 → fail_code=3. Each done arrives within 3 cycles of start.
- n=1, m=2 → pass=1. Then n=30, m=7 → pass=1, with k=2..6 all rejected before acceptance.
- n=34596, m=5: assert reset during GCD → all outputs 0 immediately; no done pulse. A fresh start then gives pass=1. With RELPRIME_CHECK_CYCLES_EN defined, cycles is nonzero and holds after done.
